// File: rtl/lfsr_burst_pkg.sv
// Shared types, constants and the Galois step function for the LFSR burst stimulus generator.
package lfsr_burst_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 16'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR register with seed load, step enable and all-zero seed substitution.
module lfsr16_galois
    import lfsr_burst_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              advance,
    output logic [WIDTH-1:0]  sample
);

    // An all-zero state would lock the LFSR, so zero seeds are replaced.
    localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? LFSR_SAFE_SEED : SEED;

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= RESET_VAL;
        end else if (load) begin
            lfsr_q <= (seed_in == '0) ? LFSR_SAFE_SEED : seed_in;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign sample = lfsr_q[WIDTH-1:0];

endmodule

// File: rtl/lfsr_burst_stim_gen.sv
// Burst stimulus source: NUM_SAMPLES LFSR samples, each held HOLD_CYCLES clocks, with min/max/sum.
// Define LFSR_BURST_FINAL_REPORT_EN for a simulation-only end-of-run report.
module lfsr_burst_stim_gen
    import lfsr_burst_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NUM_SAMPLES = 20,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic                                        seed_load,
    input  logic [15:0]                                 seed_in,
    output logic [WIDTH-1:0]                            value,
    output logic                                        valid,
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]            sample_cnt,
    output logic [WIDTH-1:0]                            min_val,
    output logic [WIDTH-1:0]                            max_val,
    output logic [WIDTH+$clog2(NUM_SAMPLES+1)-1:0]      sum
);

    localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned SW = WIDTH + CW;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] NUM_LAST = CW'(NUM_SAMPLES);

    state_t state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] issued_q, issued_d;
    logic issue, seed_accept, clear_stats;

    logic [WIDTH-1:0] lfsr_sample;
    logic [WIDTH-1:0] value_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] min_q, max_q;
    logic [SW-1:0]    sum_q;

    lfsr16_galois #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (seed_accept),
        .seed_in (seed_in),
        .advance (issue),
        .sample  (lfsr_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        issued_d    = issued_q;
        issue       = 1'b0;
        seed_accept = 1'b0;
        clear_stats = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // seed_load has priority; a simultaneous start is dropped.
                if (seed_load) begin
                    seed_accept = 1'b1;
                end else if (start) begin
                    state_d     = RUN;
                    clear_stats = 1'b1;
                    issue       = 1'b1;
                    hold_d      = '0;
                    issued_d    = CW'(1);
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DONE;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (issued_q == NUM_LAST) begin
                        state_d = DONE;
                    end else begin
                        issue    = 1'b1;
                        issued_d = issued_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Statistics fold in the sample presented during the preceding valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            issued_q <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            min_q    <= '1;
            max_q    <= '0;
            sum_q    <= '0;
        end else begin
            hold_q   <= hold_d;
            issued_q <= issued_d;
            valid_q  <= issue;
            if (issue) begin
                value_q <= lfsr_sample;
            end
            if (clear_stats) begin
                cnt_q <= '0;
                min_q <= '1;
                max_q <= '0;
                sum_q <= '0;
            end else if (valid_q) begin
                cnt_q <= cnt_q + 1'b1;
                sum_q <= sum_q + SW'(value_q);
                if (value_q < min_q) begin
                    min_q <= value_q;
                end
                if (value_q > max_q) begin
                    max_q <= value_q;
                end
            end
        end
    end

    assign value      = value_q;
    assign valid      = valid_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign sample_cnt = cnt_q;
    assign min_val    = min_q;
    assign max_val    = max_q;
    assign sum        = sum_q;

`ifdef LFSR_BURST_FINAL_REPORT_EN
    final begin
        $display("lfsr_burst_stim_gen %m: sample_cnt=%0d min_val=%0d max_val=%0d sum=%0d at %0t",
                 sample_cnt, min_val, max_val, sum, $time);
        if (busy) begin
            $warning("lfsr_burst_stim_gen %m: simulation ended while a burst was running");
        end
    end
`else
    // Synthesis build: no end-of-run report.
`endif

endmodule

// File: doc/lfsr_burst_stim_gen.md
Name: lfsr_burst_stim_gen

Overview:
- Parametrised synthesizable successor to the team's free-running random stimulus driver.
- Emits a burst of NUM_SAMPLES pseudo-random WIDTH-bit values from a 16-bit Galois LFSR. Each value is held HOLD_CYCLES clocks.
- Accumulates min/max/sum statistics over the burst.
- Sits on the bench/DUT boundary as a reusable stimulus source with an end-of-run summary.

Parameters:
- WIDTH, 5, sample width in bits; legal range 1..16; output is lfsr[WIDTH-1:0].
- NUM_SAMPLES, 20, samples per burst; minimum 1.
- HOLD_CYCLES, 1, clocks each sample is held; minimum 1.
- SEED, 16'hACE1, LFSR value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin burst; honoured in IDLE or DONE only.
- stop  in  1  abort burst; honoured in RUN only.
- seed_load  in  1  load seed_in into the LFSR; honoured in IDLE or DONE only.
- seed_in  in  16  new seed; value 0 is replaced by 16'h0001.
- value  out  WIDTH  current sample.
- valid  out  1  one-cycle pulse on the first cycle of each sample.
- busy  out  1  high in RUN.
- done  out  1  high in DONE; sticky until start or rst.
- sample_cnt  out  $clog2(NUM_SAMPLES+1)  samples issued this burst.
- min_val  out  WIDTH  minimum sample this burst.
- max_val  out  WIDTH  maximum sample this burst.
- sum  out  WIDTH+$clog2(NUM_SAMPLES+1)  sum of samples this burst; sized so it cannot overflow.

Behaviour:
- Reset values:
  - FSM=IDLE, lfsr=SEED (0 becomes 1), value=0, valid=0, busy=0, done=0, sample_cnt=0, min_val=all-ones, max_val=0, sum=0.
  - rst mid-burst takes effect at the next edge and discards partial statistics.
- LFSR step: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only when a new sample is issued.
- IDLE:
  - seed_load loads the seed.
  - start clears the statistics (same values as reset) and moves to RUN.
  - If start and seed_load are both high, seed_load wins that cycle and start is ignored.
- RUN:
  - First cycle in RUN: value=lfsr[WIDTH-1:0], valid=1, sample_cnt increments, LFSR advances.
  - A hold counter runs 0..HOLD_CYCLES-1. A new sample issues when it wraps, so sample k has valid high at cycle 1+k*HOLD_CYCLES after start.
  - After the last sample has been held HOLD_CYCLES cycles, the FSM moves to DONE. done rises at cycle NUM_SAMPLES*HOLD_CYCLES+1 after start.
  - stop: moves to DONE at the next edge with partial statistics. If it coincides with a valid cycle, that sample is counted.
  - start and seed_load are ignored in RUN.
- Statistics are registered at the edge after each valid cycle and are final and stable whenever done=1.
- DONE:
  - value holds the last sample.
  - start clears the statistics and runs a new burst; the LFSR continues its sequence unless seed_load is used first.
  - seed_load is accepted.
- HOLD_CYCLES=1: valid stays high on every RUN cycle.
- NUM_SAMPLES=1: one sample is issued, then DONE.
- min/max compare unsigned.

Optional Feature:
- Macro: LFSR_BURST_FINAL_REPORT_EN.
- Defined: a simulation-only final block prints sample_cnt, min_val, max_val, sum and $time. It also issues a $warning if the simulation ends while busy=1. The final block contains no delays and no blocking tasks.
- Undefined: no final block. RTL is otherwise identical and fully synthesizable.

Decomposition:
- Package lfsr_burst_pkg holds:
  - state_t enum {IDLE, RUN, DONE}.
  - LFSR_W=16.
  - LFSR_POLY=16'hB400.
  - LFSR_SAFE_SEED=16'h0001.
  - function lfsr_next().
- Sub-module lfsr16_galois holds the LFSR register with load, advance and zero-seed substitution. The FSM, hold counter and statistics stay in the top module.

Test Plan:
1. WIDTH=5, NUM_SAMPLES=3, HOLD_CYCLES=1. seed_load with seed_in=16'h0001, then start. Required:
   - valid at cycles 1,2,3 with values 1,0,0; done at cycle 4.
   - sample_cnt=3, min_val=0, max_val=1, sum=1.
2. Defaults (WIDTH=5, NUM_SAMPLES=20, HOLD_CYCLES=1). Reset, then start. Required:
   - First value=1 (16'hACE1), second value=16 (16'hE270).
   - 20 valid pulses; done at cycle 21.
   - sum equals the bench model's value.
3. HOLD_CYCLES=4, NUM_SAMPLES=2. Required:
   - valid at cycles 1 and 5 only; value stable across each hold.
   - done at cycle 9.
4. stop asserted at cycle 3 of the default burst. Required:
   - DONE at the next edge; sample_cnt=3; min/max/sum cover those 3 samples only.
   - A following start restarts with cleared statistics.
5. seed_in=0 with seed_load in IDLE, then a burst. Required: behaves exactly as seed 16'h0001 (values 1,0,0…).
6. rst at cycle 5 mid-burst. Required:
   - Next cycle: IDLE, all outputs at reset values.
   - start/seed_load asserted during RUN are ignored.
   - With LFSR_BURST_FINAL_REPORT_EN defined, the final summary is printed.
